// File: rtl/display_regs.sv
// Purpose: bus register front end for the 4-digit 7-segment display (hex passthrough or double-dabble BCD).
// Latency: hex refresh 1 cycle after the write; decimal refresh 17 cycles after the write (busy meanwhile).
// Backpressure: none; every write is accepted, and a write during conversion restarts it (latest wins).
module display_regs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  num0,
    output logic [3:0]  num1,
    output logic [3:0]  num2,
    output logic [3:0]  num3,
    output logic [3:0]  nums_enable,
    output logic [3:0]  dots_enable,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [15:0] DEC_MAX = 16'd9999;

    // Bus-visible registers
    logic [15:0] value_q;
    logic        mode_q;
    logic        blank_q;
    logic [3:0]  dots_q;
    logic [3:0]  mask_q;
    logic        ovf_q;

    // Conversion / refresh state
    state_t      state_q;
    logic [3:0]  iter_q;
    logic [15:0] bcd_q;
    logic [15:0] opnd_q;
    logic        ovf_pend_q;
    logic        hex_pend_q;
    logic [15:0] nums_q;
    logic [3:0]  nums_en_q;
    logic [3:0]  dots_en_q;

    // Write decode and the register values as they will be after this edge
    logic        wr_value;
    logic        wr_ctrl;
    logic        refresh;
    logic [15:0] value_nxt;
    logic        mode_nxt;
    logic        sat_nxt;

    assign wr_value  = we && (addr == 2'd0);
    assign wr_ctrl   = we && (addr == 2'd1);
    assign refresh   = wr_value || wr_ctrl;
    assign value_nxt = wr_value ? wdata[15:0] : value_q;
    assign mode_nxt  = wr_ctrl ? wdata[0] : mode_q;
    assign sat_nxt   = (value_nxt > DEC_MAX);

    // Bits of the write bus that no register uses
    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:16], wdata[3:2]};

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd, operand} left
    logic [15:0] bcd_adj;
    logic [15:0] bcd_shift;
    logic [15:0] opnd_shift;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        {bcd_shift, opnd_shift} = {bcd_adj, opnd_q} << 1;
    end

    // Digit enables: mask gates everything; blanking hides zeros left of the first nonzero digit
    function automatic logic [3:0] digit_en(input logic [15:0] d,
                                            input logic [3:0]  m,
                                            input logic        b);
        logic [3:0] e;
        e[0] = m[0];
        e[1] = m[1] & (~b | (|d[15:4]));
        e[2] = m[2] & (~b | (|d[15:8]));
        e[3] = m[3] & (~b | (|d[15:12]));
        return e;
    endfunction

    // VALUE and CTRL registers take bus writes directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 16'd0;
            mode_q  <= 1'b1;
            blank_q <= 1'b1;
            dots_q  <= 4'd0;
            mask_q  <= 4'hF;
        end else begin
            if (wr_value) begin
                value_q <= wdata[15:0];
            end
            if (wr_ctrl) begin
                mode_q  <= wdata[0];
                blank_q <= wdata[1];
                dots_q  <= wdata[7:4];
                mask_q  <= wdata[11:8];
            end
        end
    end

    // Refresh FSM: hex loads one cycle after a trigger, decimal runs 16 shifts then LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            iter_q     <= 4'd0;
            bcd_q      <= 16'd0;
            opnd_q     <= 16'd0;
            ovf_pend_q <= 1'b0;
            hex_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            nums_q     <= 16'd0;
            nums_en_q  <= 4'b0001;
            dots_en_q  <= 4'd0;
        end else begin
            // A pending hex refresh completes from the registers written last cycle
            if (state_q == IDLE && hex_pend_q) begin
                nums_q     <= value_q;
                nums_en_q  <= digit_en(value_q, mask_q, blank_q);
                dots_en_q  <= dots_q;
                ovf_q      <= 1'b0;
                hex_pend_q <= 1'b0;
            end

            case (state_q)
                CONV: begin
                    bcd_q  <= bcd_shift;
                    opnd_q <= opnd_shift;
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'd15) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // A write landing on this edge supersedes the finished result
                    if (!refresh) begin
                        nums_q    <= bcd_q;
                        nums_en_q <= digit_en(bcd_q, mask_q, blank_q);
                        dots_en_q <= dots_q;
                        ovf_q     <= ovf_pend_q;
                    end
                    state_q <= IDLE;
                end
                default: ;
            endcase

            // Any VALUE/CTRL write restarts the refresh using the freshly written registers
            if (refresh) begin
                if (mode_nxt) begin
                    state_q    <= CONV;
                    iter_q     <= 4'd0;
                    bcd_q      <= 16'd0;
                    opnd_q     <= sat_nxt ? DEC_MAX : value_nxt;
                    ovf_pend_q <= sat_nxt;
                    hex_pend_q <= 1'b0;
                end else begin
                    state_q    <= IDLE;
                    hex_pend_q <= 1'b1;
                end
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign num0        = nums_q[3:0];
    assign num1        = nums_q[7:4];
    assign num2        = nums_q[11:8];
    assign num3        = nums_q[15:12];
    assign nums_enable = nums_en_q;
    assign dots_enable = dots_en_q;

    // Read mux, combinational and side-effect free
    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {16'd0, value_q};
            2'd1:    rdata = {20'd0, mask_q, dots_q, 2'b00, blank_q, mode_q};
            2'd2:    rdata = {30'd0, ovf_q, busy};
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_display_regs.sv
module tb_display_regs;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  num0, num1, num2, num3;
    logic [3:0]  nums_enable;
    logic [3:0]  dots_enable;
    logic        busy;
    logic [15:0] nums;

    int checks = 0;
    int errors = 0;

    assign nums = {num3, num2, num1, num0};

    display_regs dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .num0        (num0),
        .num1        (num1),
        .num2        (num2),
        .num3        (num3),
        .nums_enable (nums_enable),
        .dots_enable (dots_enable),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ctrl;
        logic [15:0] value;
        logic [15:0] nums;
        logic [3:0]  en;
        logic [3:0]  dots;
        logic [1:0]  status;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edge then settle: leaves time 1 unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write presented at a negedge, sampled at the next rising edge k; returns at k+1
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    logic [31:0] r;

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;

        //          ctrl        value      nums      en    dots  status
        vecs[0] = '{32'h0000_0F03, 16'd1234,  16'h1234, 4'hF, 4'h0, 2'd0};
        vecs[1] = '{32'h0000_0F03, 16'd40,    16'h0040, 4'h3, 4'h0, 2'd0};
        vecs[2] = '{32'h0000_0F03, 16'hFFFF,  16'h9999, 4'hF, 4'h0, 2'd2};
        vecs[3] = '{32'h0000_0F50, 16'hA0C3,  16'hA0C3, 4'hF, 4'h5, 2'd0};
        vecs[4] = '{32'h0000_0F03, 16'd0,     16'h0000, 4'h1, 4'h0, 2'd0};
        vecs[5] = '{32'h0000_F0F1, 16'd7,     16'h0007, 4'h0, 4'hF, 2'd0};
        vecs[6] = '{32'h0000_0503, 16'd305,   16'h0305, 4'h5, 4'h0, 2'd0};
        vecs[7] = '{32'h0000_0FA2, 16'h00F0,  16'h00F0, 4'h3, 4'hA, 2'd0};
        vecs[8] = '{32'h0000_0F33, 16'd10000, 16'h9999, 4'hF, 4'h3, 2'd2};
        vecs[9] = '{32'h0000_0F03, 16'd9999,  16'h9999, 4'hF, 4'h0, 2'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_nums", {16'd0, nums}, 32'd0);
        check("rst_en", {28'd0, nums_enable}, 32'h1);
        check("rst_dots", {28'd0, dots_enable}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rd(2'd2, r); check("rst_status", r, 32'd0);
        rd(2'd1, r); check("rst_ctrl", r, 32'h0000_0F03);
        rd(2'd0, r); check("rst_value", r, 32'd0);
        rd(2'd3, r); check("rst_addr3", r, 32'd0);

        // Table: program CTRL then VALUE, let the refresh finish, compare everything
        for (int i = 0; i < 10; i++) begin
            wr(2'd1, vecs[i].ctrl);
            wr(2'd0, {16'hDEAD, vecs[i].value});
            repeat (20) tick();
            check($sformatf("v%0d_nums", i), {16'd0, nums}, {16'd0, vecs[i].nums});
            check($sformatf("v%0d_en", i), {28'd0, nums_enable}, {28'd0, vecs[i].en});
            check($sformatf("v%0d_dots", i), {28'd0, dots_enable}, {28'd0, vecs[i].dots});
            rd(2'd2, r); check($sformatf("v%0d_status", i), r, {30'd0, vecs[i].status});
            rd(2'd0, r); check($sformatf("v%0d_value", i), r, {16'd0, vecs[i].value});
            rd(2'd1, r); check($sformatf("v%0d_ctrl", i), r, vecs[i].ctrl & 32'h0000_0FF3);
        end

        // Writes to STATUS and addr 3 change nothing and start no refresh
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        check("ro_busy", {31'd0, busy}, 32'd0);
        rd(2'd2, r); check("ro_status", r, 32'd0);
        rd(2'd3, r); check("ro_addr3", r, 32'd0);

        // Decimal latency: busy from k, digits frozen through k+16, result at k+17
        wr(2'd0, 32'd1234);
        check("dec_busy_k", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("dec_busy_k%0d", i), {31'd0, busy}, 32'd1);
            check($sformatf("dec_frozen_k%0d", i), {16'd0, nums}, 32'h9999);
        end
        tick();
        check("dec_busy_k17", {31'd0, busy}, 32'd0);
        check("dec_nums_k17", {16'd0, nums}, 32'h1234);
        check("dec_en_k17", {28'd0, nums_enable}, 32'hF);

        // Restart: 5678 interrupted at cycle 8 by 42; 5678 never shows
        wr(2'd0, 32'd5678);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("rs_hold_a%0d", i), {16'd0, nums}, 32'h1234);
        end
        wr(2'd0, 32'd42);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("rs_hold_b%0d", i), {16'd0, nums}, 32'h1234);
            check($sformatf("rs_busy_b%0d", i), {31'd0, busy}, 32'd1);
        end
        tick();
        check("rs_nums", {16'd0, nums}, 32'h0042);
        check("rs_en", {28'd0, nums_enable}, 32'h3);
        check("rs_busy_end", {31'd0, busy}, 32'd0);

        // Hex latency with back-to-back CTRL then VALUE writes
        wr(2'd1, 32'h0000_0F50);
        wr(2'd0, 32'h0000_1234);
        check("hex_k_old", {16'd0, nums}, 32'h002A);
        check("hex_k_dots", {28'd0, dots_enable}, 32'h5);
        tick();
        check("hex_k1_nums", {16'd0, nums}, 32'h1234);
        check("hex_k1_busy", {31'd0, busy}, 32'd0);

        // Abort: decimal conversion of 255 cut off by a switch to hex
        wr(2'd1, 32'h0000_0F03);
        repeat (20) tick();
        check("ab_pre", {16'd0, nums}, 32'h4660);
        wr(2'd0, 32'd255);
        repeat (5) tick();
        wr(2'd1, 32'h0000_0F50);
        tick();
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_nums", {16'd0, nums}, 32'h00FF);
        check("ab_en", {28'd0, nums_enable}, 32'hF);
        repeat (20) tick();
        check("ab_stable", {16'd0, nums}, 32'h00FF);

        // Asynchronous reset in the middle of a conversion
        wr(2'd1, 32'h0000_0F03);
        repeat (20) tick();
        check("ar_pre_nums", {16'd0, nums}, 32'h0255);
        check("ar_pre_en", {28'd0, nums_enable}, 32'h7);
        wr(2'd0, 32'd5678);
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_nums", {16'd0, nums}, 32'd0);
        check("ar_en", {28'd0, nums_enable}, 32'h1);
        check("ar_dots", {28'd0, dots_enable}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        rd(2'd2, r); check("ar_status", r, 32'd0);
        rd(2'd1, r); check("ar_ctrl", r, 32'h0000_0F03);
        rd(2'd0, r); check("ar_value", r, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) tick();
        check("ar_post_nums", {16'd0, nums}, 32'd0);
        check("ar_post_en", {28'd0, nums_enable}, 32'h1);
        check("ar_post_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
